// File: rtl/lut_lookup_sched.sv
// lut_lookup_sched
//   Small key/data lookup table shared by two requesters. A round-robin
//   arbiter picks one request in IDLE. The key is compared against every
//   enabled entry in CMP. The result is held in RESP until the consumer
//   takes it. One lookup is in flight at a time, so the rate is one lookup
//   per 3 clocks at best.
//
// Optional feature: define LUT_LOOKUP_SCHED_STATS_EN to build saturating
//   lookup/miss counters. Without it the stat ports read constant 0.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   cfg_we/idx/key/data/en     table write port; out-of-range idx is dropped
//   default_out                value returned on a miss when HAS_DEFAULT=1
//   reqN_valid/key/ready       lookup requesters 0 and 1 (valid/ready)
//   rsp_valid/ready            response handshake
//   rsp_id/data/hit            response payload
//   stat_lookups/misses        16-bit saturating statistics
module lut_lookup_sched #(
  parameter int NR_KEY      = 4,
  parameter int KEY_LEN     = 4,
  parameter int DATA_LEN    = 8,
  parameter int HAS_DEFAULT = 1,
  localparam int IDX_W      = (NR_KEY > 1) ? $clog2(NR_KEY) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [KEY_LEN-1:0]  cfg_key,
  input  logic [DATA_LEN-1:0] cfg_data,
  input  logic                cfg_en,
  input  logic [DATA_LEN-1:0] default_out,
  input  logic                req0_valid,
  input  logic [KEY_LEN-1:0]  req0_key,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [KEY_LEN-1:0]  req1_key,
  output logic                req1_ready,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [DATA_LEN-1:0] rsp_data,
  output logic                rsp_hit,
  output logic [15:0]         stat_lookups,
  output logic [15:0]         stat_misses
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]                      r_state;
  logic [NR_KEY-1:0]               r_en;
  logic [NR_KEY-1:0][KEY_LEN-1:0]  r_key;
  logic [NR_KEY-1:0][DATA_LEN-1:0] r_data;
  logic [KEY_LEN-1:0]              r_req_key;
  logic                            r_req_id;
  logic                            r_last;     // id of the last grant
  logic                            r_rsp_id;
  logic                            r_rsp_hit;
  logic [DATA_LEN-1:0]             r_rsp_data;

  logic                            w_idle;
  logic                            w_any;
  logic                            w_gid;
  logic [NR_KEY-1:0]               w_match;
  logic [DATA_LEN-1:0]             w_or;
  logic                            w_hit;
  logic [DATA_LEN-1:0]             w_lut_data;

  // Arbitration. On a tie, the requester that was not granted last wins.
  // r_last resets to 1, so req0 wins the first tie after reset.
  assign w_idle = (r_state == S_IDLE);
  assign w_any  = req0_valid | req1_valid;
  assign w_gid  = (req0_valid & req1_valid) ? ~r_last : req1_valid;

  assign req0_ready = w_idle & req0_valid & ~w_gid;
  assign req1_ready = w_idle & req1_valid &  w_gid;

  // Table storage. An index at or above NR_KEY matches no entry, so such
  // writes fall through untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en   <= '0;
      r_key  <= '0;
      r_data <= '0;
    end else if (cfg_we) begin
      for (int i = 0; i < NR_KEY; i++) begin
        if (cfg_idx == IDX_W'(i)) begin
          r_en[i]   <= cfg_en;
          r_key[i]  <= cfg_key;
          r_data[i] <= cfg_data;
        end
      end
    end
  end

  // Parallel compare. When several entries match, their data is ORed.
  // The table registers are read before the CMP edge updates them, so a
  // write on that same edge is not seen by the current lookup.
  always_comb begin
    w_match = '0;
    w_or    = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      w_match[i] = r_en[i] && (r_key[i] == r_req_key);
      if (w_match[i]) w_or = w_or | r_data[i];
    end
  end

  assign w_hit      = |w_match;
  assign w_lut_data = w_hit ? w_or : ((HAS_DEFAULT != 0) ? default_out : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_last     <= 1'b1;
      r_req_key  <= '0;
      r_req_id   <= 1'b0;
      r_rsp_id   <= 1'b0;
      r_rsp_hit  <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any) begin
          r_req_key <= w_gid ? req1_key : req0_key;
          r_req_id  <= w_gid;
          r_last    <= w_gid;
          r_state   <= S_CMP;
        end
        S_CMP: begin
          r_rsp_data <= w_lut_data;
          r_rsp_hit  <= w_hit;
          r_rsp_id   <= r_req_id;
          r_state    <= S_RESP;
        end
        // Go back to IDLE only. A new grant waits for the next cycle.
        S_RESP: if (rsp_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid = (r_state == S_RESP);
  assign rsp_id    = r_rsp_id;
  assign rsp_hit   = r_rsp_hit;
  assign rsp_data  = r_rsp_data;

`ifdef LUT_LOOKUP_SCHED_STATS_EN
  logic [15:0] r_lookups;
  logic [15:0] r_misses;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lookups <= '0;
      r_misses  <= '0;
    end else if (r_state == S_CMP) begin
      if (r_lookups != 16'hFFFF) r_lookups <= r_lookups + 16'd1;
      if (!w_hit && (r_misses != 16'hFFFF)) r_misses <= r_misses + 16'd1;
    end
  end

  assign stat_lookups = r_lookups;
  assign stat_misses  = r_misses;
`else
  assign stat_lookups = 16'd0;
  assign stat_misses  = 16'd0;
`endif

endmodule

// File: tb/tb_lut_lookup_sched.sv
// Bench for lut_lookup_sched: NR_KEY=3 so that out-of-range indices exist.
// Directed cases use literal expectations. A transaction-level model
// predicts the outputs, and every cycle they are compared against it.
module tb_lut_lookup_sched;

  localparam int NR = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_we, cfg_en;
  logic [1:0] cfg_idx;
  logic [3:0] cfg_key;
  logic [7:0] cfg_data, default_out;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0] req0_key, req1_key;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_hit;
  logic [7:0] rsp_data;
  logic [15:0] stat_lookups, stat_misses;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lut_lookup_sched #(.NR_KEY(NR), .KEY_LEN(4), .DATA_LEN(8), .HAS_DEFAULT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_key(cfg_key), .cfg_data(cfg_data), .cfg_en(cfg_en),
    .default_out(default_out),
    .req0_valid(req0_valid), .req0_key(req0_key), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_key(req1_key), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_hit(rsp_hit),
    .stat_lookups(stat_lookups), .stat_misses(stat_misses)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // m_age counts the cycles since an accept: 0 means free, 1 means the
  // lookup is evaluated on the next edge, 2 means the response is shown.
  int         m_age;
  logic       m_last;
  logic       m_id, m_h;
  logic [3:0] m_k;
  logic [7:0] m_d;
  logic       m_en [NR];
  logic [3:0] m_tk [NR];
  logic [7:0] m_td [NR];
  int         m_look, m_miss;

  function automatic logic [7:0] exp_data(input logic [3:0] k);
    logic [7:0] r;
    logic any;
    r = 8'h00; any = 1'b0;
    for (int i = 0; i < NR; i++)
      if (m_en[i] && m_tk[i] == k) begin r = r | m_td[i]; any = 1'b1; end
    return any ? r : default_out;
  endfunction

  function automatic logic exp_hit(input logic [3:0] k);
    logic any;
    any = 1'b0;
    for (int i = 0; i < NR; i++) if (m_en[i] && m_tk[i] == k) any = 1'b1;
    return any;
  endfunction

  function automatic logic exp_gid();
    if (req0_valid && req1_valid) return ~m_last;
    return req1_valid;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age <= 0; m_last <= 1'b1; m_id <= 1'b0; m_h <= 1'b0; m_k <= 4'h0; m_d <= 8'h00;
      m_look <= 0; m_miss <= 0;
      for (int i = 0; i < NR; i++) begin m_en[i] <= 1'b0; m_tk[i] <= 4'h0; m_td[i] <= 8'h00; end
    end else begin
      case (m_age)
        0: if (req0_valid || req1_valid) begin
          m_id <= exp_gid(); m_last <= exp_gid();
          m_k  <= exp_gid() ? req1_key : req0_key;
          m_age <= 1;
        end
        1: begin
          m_d <= exp_data(m_k); m_h <= exp_hit(m_k); m_age <= 2;
          if (m_look < 65535) m_look <= m_look + 1;
          if (!exp_hit(m_k) && m_miss < 65535) m_miss <= m_miss + 1;
        end
        default: if (rsp_ready) m_age <= 0;
      endcase
      if (cfg_we && cfg_idx < NR) begin
        m_en[cfg_idx] <= cfg_en; m_tk[cfg_idx] <= cfg_key; m_td[cfg_idx] <= cfg_data;
      end
    end
  end

  // Every-cycle compare, run after the stimulus has settled.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (rst_n) begin
        chk("ready0", req0_ready, (m_age == 0) && req0_valid && !exp_gid());
        chk("ready1", req1_ready, (m_age == 0) && req1_valid && exp_gid());
        chk("rsp_valid", rsp_valid, m_age == 2);
        if (m_age == 2) begin
          chk("rsp_data", rsp_data, m_d);
          chk("rsp_hit", rsp_hit, m_h);
          chk("rsp_id", rsp_id, m_id);
        end
`ifdef LUT_LOOKUP_SCHED_STATS_EN
        chk("stat_lookups", stat_lookups, m_look);
        chk("stat_misses", stat_misses, m_miss);
`else
        chk("stat_lookups", stat_lookups, 0);
        chk("stat_misses", stat_misses, 0);
`endif
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input logic [1:0] idx, input logic en, input logic [3:0] k, input logic [7:0] d);
    cfg_we = 1'b1; cfg_idx = idx; cfg_en = en; cfg_key = k; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // mode 1 writes idx0 {1,3,0x33} on the CMP edge of this lookup.
  task automatic lookup(input logic id, input logic [3:0] k, input int mode,
                        output logic [7:0] d, output logic h, output logic rid, output int lat);
    logic acc;
    acc = 1'b0; lat = -1; d = 8'h00; h = 1'b0; rid = 1'b0;
    if (id) begin req1_valid = 1'b1; req1_key = k; end
    else    begin req0_valid = 1'b1; req0_key = k; end
    for (int c = 0; c < 30 && !acc; c++) begin
      #1 acc = id ? req1_ready : req0_ready;
      @(negedge clk);
    end
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    if (!acc) begin chk("accept_timeout", 0, 1); return; end
    if (mode == 1) begin cfg_we = 1'b1; cfg_idx = 2'd0; cfg_en = 1'b1; cfg_key = 4'h3; cfg_data = 8'h33; end
    for (int c = 1; c < 30; c++) begin
      #1;
      if (rsp_valid) begin lat = c; d = rsp_data; h = rsp_hit; rid = rsp_id; break; end
      @(negedge clk);
      cfg_we = 1'b0;
    end
    if (lat < 0) chk("rsp_timeout", 0, 1);
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  logic [7:0] d;
  logic       h, rid;
  int         lat;
  int         g [4];
  int         ng;
  logic       acc0, acc1;

  initial begin
    rst_n = 1'b1; cfg_we = 1'b0; cfg_en = 1'b0; cfg_idx = '0; cfg_key = '0; cfg_data = '0;
    default_out = 8'h5C; req0_valid = 1'b0; req1_valid = 1'b0; req0_key = '0; req1_key = '0;
    rsp_ready = 1'b1;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_hit", rsp_hit, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_stat_lookups", stat_lookups, 0);
    chk("rst_stat_misses", stat_misses, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Both requesters valid all the time: grants must alternate, starting with req0.
    req0_valid = 1'b1; req0_key = 4'h1; req1_valid = 1'b1; req1_key = 4'h2;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      #1;
      if (req0_ready) begin g[ng] = 0; ng++; end
      else if (req1_ready) begin g[ng] = 1; ng++; end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("grant_count", ng, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("grant%0d", i), (i < ng) ? g[i] : 9, i % 2);
    repeat (3) @(negedge clk);
    pulse_reset();

    // Basic hit, then a miss that returns default_out.
    wr(2'd0, 1'b1, 4'h3, 8'hA5);
    lookup(1'b0, 4'h3, 0, d, h, rid, lat);
    chk("hit_latency", lat, 2);
    chk("hit_data", d, 8'hA5);
    chk("hit_hit", h, 1);
    chk("hit_id", rid, 0);
    lookup(1'b1, 4'h7, 0, d, h, rid, lat);
    chk("miss_data", d, 8'h5C);
    chk("miss_hit", h, 0);
    chk("miss_id", rid, 1);
`ifdef LUT_LOOKUP_SCHED_STATS_EN
    chk("miss_stat_misses", stat_misses, 1);
    chk("miss_stat_lookups", stat_lookups, 2);
`else
    chk("miss_stat_misses", stat_misses, 0);
    chk("miss_stat_lookups", stat_lookups, 0);
`endif

    // Multiple matches are ORed; disabling an entry removes it.
    wr(2'd0, 1'b1, 4'h3, 8'h0F);
    wr(2'd1, 1'b1, 4'h3, 8'hF0);
    lookup(1'b0, 4'h3, 0, d, h, rid, lat);
    chk("or_data", d, 8'hFF);
    wr(2'd1, 1'b0, 4'h3, 8'hF0);
    lookup(1'b1, 4'h3, 0, d, h, rid, lat);
    chk("dis_data", d, 8'h0F);
    // Index 3 is outside the table and must be ignored.
    wr(2'd3, 1'b1, 4'h3, 8'hF0);
    lookup(1'b0, 4'h3, 0, d, h, rid, lat);
    chk("oor_data", d, 8'h0F);

    // Write on the CMP edge: old data now, new data next time.
    lookup(1'b0, 4'h3, 1, d, h, rid, lat);
    chk("cmpwr_old", d, 8'h0F);
    lookup(1'b1, 4'h3, 0, d, h, rid, lat);
    chk("cmpwr_new", d, 8'h33);

    // Backpressure: hold rsp_ready low; outputs stay stable and no grant is made.
    rsp_ready = 1'b0;
    lookup(1'b0, 4'h3, 0, d, h, rid, lat);
    req1_valid = 1'b1; req1_key = 4'h5;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall_valid", rsp_valid, 1);
      chk("stall_data", rsp_data, 8'h33);
      chk("stall_id", rsp_id, 0);
      chk("stall_ready0", req0_ready, 0);
      chk("stall_ready1", req1_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1 chk("release_idle_ready1", req1_ready, 1);
    @(negedge clk);
    req1_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Reset during CMP: the response must never appear.
    req0_valid = 1'b1; req0_key = 4'h3;
    acc0 = 1'b0;
    for (int c = 0; c < 10 && !acc0; c++) begin #1 acc0 = req0_ready; @(negedge clk); end
    req0_valid = 1'b0;
    chk("rstcmp_accept", acc0, 1);
    #1 rst_n = 1'b0;
    #1 chk("rstcmp_in_reset", rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin #1 chk("rstcmp_no_rsp", rsp_valid, 0); @(negedge clk); end

    // Random traffic against the model.
    acc0 = 1'b0; acc1 = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!req0_valid || acc0) begin req0_valid = $urandom_range(0, 1); req0_key = $urandom_range(0, 7); end
      if (!req1_valid || acc1) begin req1_valid = $urandom_range(0, 1); req1_key = $urandom_range(0, 7); end
      cfg_we   = ($urandom_range(0, 5) == 0);
      cfg_idx  = $urandom_range(0, 3);
      cfg_en   = ($urandom_range(0, 3) != 0);
      cfg_key  = $urandom_range(0, 7);
      cfg_data = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) default_out = $urandom;
      #1;
      acc0 = req0_valid & req0_ready;
      acc1 = req1_valid & req1_ready;
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; cfg_we = 1'b0; rsp_ready = 1'b1;
    repeat (6) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/lut_lookup_sched.md
LUT_LOOKUP_SCHED -- requirements
Module: lut_lookup_sched

Interface
REQ-001 SHALL have parameter NR_KEY, default 4: number of table entries, 2..16.
REQ-002 SHALL have parameter KEY_LEN, default 4: key width.
REQ-003 SHALL have parameter DATA_LEN, default 8: data width.
REQ-004 SHALL have parameter HAS_DEFAULT, default 1: on a miss, return default_out (1) or zero (0).
REQ-005 SHALL have ports as listed (name, direction, width, meaning), with one clock and an asynchronous active-low reset:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  table write strobe.
- cfg_idx  in  clog2(NR_KEY)  entry index.
- cfg_key  in  KEY_LEN  key to store.
- cfg_data  in  DATA_LEN  data to store.
- cfg_en  in  1  valid bit to store.
- default_out  in  DATA_LEN  miss value.
- req0_valid / req1_valid  in  1  lookup request.
- req0_key / req1_key  in  KEY_LEN  lookup key.
- req0_ready / req1_ready  out  1  request accepted.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_id  out  1  requester index.
- rsp_data  out  DATA_LEN  lookup result.
- rsp_hit  out  1  key matched.
- stat_lookups  out  16  lookup count.
- stat_misses  out  16  miss count.

Function
REQ-006 SHALL hold NR_KEY entries {en, key, data}; a write occurs when cfg_we=1 at a clock edge, and entry cfg_idx takes the cfg values from that edge.
REQ-007 SHALL run a 3-state FSM: IDLE, CMP, RESP.
REQ-008 In IDLE, SHALL grant one requester with valid=1 by round-robin, and assert that requester's ready only, combinationally.
REQ-009 On the accept edge, SHALL latch the key and id, and move IDLE->CMP.
REQ-010 SHALL tie-break by the last-grant pointer; after reset, req0 wins the first tie.
REQ-011 In CMP, SHALL compute data as the OR of data over all entries with en=1 and key match, and hit as the OR of the matches.
REQ-012 In CMP, SHALL register rsp_data, rsp_hit and rsp_id, and move to RESP.
REQ-013 On a miss, rsp_data SHALL be default_out when HAS_DEFAULT=1, else 0.
REQ-014 If several enabled entries match, rsp_data SHALL be the bitwise OR of their data.
REQ-015 In RESP, rsp_valid SHALL be 1, and all outputs SHALL hold stable until rsp_ready=1.
REQ-016 On the RESP edge with rsp_ready=1, SHALL move to IDLE, with no same-cycle re-grant.
REQ-017 Latency, accept edge to rsp_valid, SHALL be 2 clocks; throughput SHALL be 1 lookup per 3 clocks with rsp_ready held high.
REQ-018 A cfg write on the CMP edge SHALL NOT affect that lookup, which sees the old contents.
REQ-019 A write SHALL be visible to any lookup whose CMP cycle starts after the write edge.
REQ-020 req*_ready SHALL be 0 outside IDLE; requesters hold valid and key until ready.
REQ-021 An out-of-range cfg_idx write SHALL be ignored.

Reset
REQ-022 On rst_n=0, asynchronously: FSM=IDLE; all entries en=0, key=0, data=0; rr pointer favours req0.
REQ-023 On rst_n=0: rsp_valid=0, rsp_data=0, rsp_hit=0, rsp_id=0, stat counters=0.
REQ-024 Reset mid-lookup SHALL drop the in-flight response without emitting it.

Configuration
REQ-025 With macro LUT_LOOKUP_SCHED_STATS_EN defined, stat_lookups SHALL increment on each CMP cycle, saturating at 0xFFFF.
REQ-026 With LUT_LOOKUP_SCHED_STATS_EN defined, stat_misses SHALL increment on each CMP cycle with hit=0, saturating at 0xFFFF.
REQ-027 Without LUT_LOOKUP_SCHED_STATS_EN, the stat ports SHALL exist and read constant 0, with no counter logic.

Verification
REQ-028 Write idx0 {1,0x3,0xA5}; req0 key=3 -> rsp_valid 2 clocks after accept, rsp_data=0xA5, rsp_hit=1, rsp_id=0.
REQ-029 Miss: key=7, default_out=0x5C, HAS_DEFAULT=1 -> rsp_data=0x5C, rsp_hit=0, stat_misses=1 (macro on).
REQ-030 req0 and req1 both valid continuously -> grants alternate 0,1,0,1, starting with 0 after reset.
REQ-031 rsp_ready=0 for 5 clocks -> rsp_* stable, both readys 0; release -> IDLE next clock.
REQ-032 Entries idx0 {1,3,0x0F} and idx1 {1,3,0xF0} -> key=3 gives 0xFF; disabling idx1 (en=0) -> 0x0F.
REQ-033 Overwrite idx0 data on the CMP edge -> old data returned; next lookup returns new data; rst_n pulse in CMP -> no rsp_valid.
